// File: rtl/sweep_pkg.sv
// Shared types and register map for the nonce sweep controller.
package sweep_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StCheck,
    StDone
  } state_e;

  localparam logic [4:0] ADDR_CTRL   = 5'd16;
  localparam logic [4:0] ADDR_NONCE  = 5'd17;
  localparam logic [4:0] ADDR_NEND   = 5'd18;
  localparam logic [4:0] ADDR_TARGET = 5'd19;
  localparam logic [4:0] ADDR_COUNT  = 5'd20;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_FOUND     = 1;
  localparam int unsigned STAT_EXHAUSTED = 2;
  localparam int unsigned STAT_TIMEOUT   = 3;

  localparam int unsigned CTRL_GO    = 0;
  localparam int unsigned CTRL_ABORT = 1;

endpackage

// File: rtl/sweep_regfile.sv
// Avalon-MM register file: block words, sweep configuration and registered read mux.
module sweep_regfile
  import sweep_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             chipselect_i,
  input  logic             write_i,
  input  logic             read_i,
  input  logic [4:0]       address_i,
  input  logic [31:0]      writedata_i,
  input  logic             busy_i,
  input  logic [3:0]       status_i,
  input  logic [31:0]      nonce_i,
  input  logic [31:0]      golden_i,
  input  logic [31:0]      count_i,
  output logic [31:0]      readdata_o,
  output logic [15:0][31:0] block_o,
  output logic [31:0]      nonce_start_o,
  output logic [31:0]      nonce_end_o,
  output logic [31:0]      target_o,
  output logic             go_o,
  output logic             abort_o
);

  logic [15:0][31:0] block_q;
  logic [31:0]       nonce_start_q, nonce_end_q, target_q, readdata_q, rdata_d;
  logic              wr_en, rd_en;

  assign wr_en = chipselect_i & write_i;
  assign rd_en = chipselect_i & read_i;

  // CTRL is decoded regardless of busy so abort always gets through.
  assign go_o    = wr_en && (address_i == ADDR_CTRL) && writedata_i[CTRL_GO];
  assign abort_o = wr_en && (address_i == ADDR_CTRL) && writedata_i[CTRL_ABORT];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      block_q       <= '0;
      nonce_start_q <= '0;
      nonce_end_q   <= '0;
      target_q      <= '0;
    end else if (wr_en && !busy_i) begin
      if (!address_i[4]) begin
        block_q[address_i[3:0]] <= writedata_i;
      end else begin
        case (address_i)
          ADDR_NONCE:  nonce_start_q <= writedata_i;
          ADDR_NEND:   nonce_end_q   <= writedata_i;
          ADDR_TARGET: target_q      <= writedata_i;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    if (!address_i[4]) begin
      rdata_d = block_q[address_i[3:0]];
    end else begin
      case (address_i)
        ADDR_CTRL:   rdata_d = {28'b0, status_i};
        ADDR_NONCE:  rdata_d = nonce_i;
        ADDR_NEND:   rdata_d = golden_i;
        ADDR_TARGET: rdata_d = target_q;
        ADDR_COUNT:  rdata_d = count_i;
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      readdata_q <= '0;
    end else if (rd_en) begin
      readdata_q <= rdata_d;
    end
  end

  assign readdata_o    = readdata_q;
  assign block_o       = block_q;
  assign nonce_start_o = nonce_start_q;
  assign nonce_end_o   = nonce_end_q;
  assign target_o      = target_q;

endmodule

// File: rtl/nonce_sweep_ctrl.sv
// Nonce sweep scheduler for the SHA-256 core; stops on first golden nonce or range end.
// Optional WATCHDOG_EN adds a WAIT-state timeout of TIMEOUT_CYCLES cycles.
module nonce_sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int unsigned NONCE_WORD     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 127
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         chipselect_i,
  input  logic         write_i,
  input  logic         read_i,
  input  logic [4:0]   address_i,
  input  logic [31:0]  writedata_i,
  output logic [31:0]  readdata_o,
  output logic [511:0] core_block_o,
  output logic         core_start_o,
  input  logic         core_done_i,
  input  logic [255:0] core_hash_i,
  output logic         irq_o
);

  state_e            state_q, state_d;
  logic [31:0]       nonce_q, nonce_d, golden_q, golden_d, count_q, count_d;
  logic [31:0]       hash_q, hash_d;  // only the top digest word feeds the compare
  logic              found_q, found_d, exh_q, exh_d, timeout_q, timeout_d;
  logic              busy, go, abort;
  logic [3:0]        status;
  logic [15:0][31:0] block;
  logic [31:0]       nonce_start, nonce_end, target;
  logic              unused_hash;

  assign unused_hash = ^core_hash_i[223:0];

`ifdef WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdW-1:0] wdog_q, wdog_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) wdog_q <= '0;
    else         wdog_q <= wdog_d;
  end
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
`endif

  sweep_regfile u_regfile (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .chipselect_i  (chipselect_i),
    .write_i       (write_i),
    .read_i        (read_i),
    .address_i     (address_i),
    .writedata_i   (writedata_i),
    .busy_i        (busy),
    .status_i      (status),
    .nonce_i       (nonce_q),
    .golden_i      (golden_q),
    .count_i       (count_q),
    .readdata_o    (readdata_o),
    .block_o       (block),
    .nonce_start_o (nonce_start),
    .nonce_end_o   (nonce_end),
    .target_o      (target),
    .go_o          (go),
    .abort_o       (abort)
  );

  assign busy = (state_q == StIssue) || (state_q == StWait) || (state_q == StCheck);

  always_comb begin
    status                 = '0;
    status[STAT_BUSY]      = busy;
    status[STAT_FOUND]     = found_q;
    status[STAT_EXHAUSTED] = exh_q;
    status[STAT_TIMEOUT]   = timeout_q;
  end

  always_comb begin
    state_d   = state_q;
    nonce_d   = nonce_q;
    golden_d  = golden_q;
    count_d   = count_q;
    hash_d    = hash_q;
    found_d   = found_q;
    exh_d     = exh_q;
    timeout_d = timeout_q;
`ifdef WATCHDOG_EN
    wdog_d    = '0;
`endif
    // Abort overrides everything else in flight, including a same-cycle core_done.
    if (busy && abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (go && !abort) begin
            found_d   = 1'b0;
            exh_d     = 1'b0;
            timeout_d = 1'b0;
            count_d   = '0;
            nonce_d   = nonce_start;
            if (nonce_end < nonce_start) begin
              exh_d   = 1'b1;
              state_d = StDone;
            end else begin
              state_d = StIssue;
            end
          end
        end
        StIssue: state_d = StWait;
        StWait: begin
          if (core_done_i) begin
            hash_d  = core_hash_i[255:224];
            count_d = (count_q == '1) ? count_q : count_q + 32'd1;
            state_d = StCheck;
          end
`ifdef WATCHDOG_EN
          else if (wdog_q == WdW'(TIMEOUT_CYCLES - 1)) begin
            timeout_d = 1'b1;
            state_d   = StDone;
          end else begin
            wdog_d = wdog_q + WdW'(1);
          end
`endif
        end
        StCheck: begin
          if (hash_q < target) begin
            golden_d = nonce_q;
            found_d  = 1'b1;
            state_d  = StDone;
          end else if (nonce_q == nonce_end) begin
            exh_d   = 1'b1;
            state_d = StDone;
          end else begin
            nonce_d = nonce_q + 32'd1;
            state_d = StIssue;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      nonce_q   <= '0;
      golden_q  <= '0;
      count_q   <= '0;
      hash_q    <= '0;
      found_q   <= 1'b0;
      exh_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      nonce_q   <= nonce_d;
      golden_q  <= golden_d;
      count_q   <= count_d;
      hash_q    <= hash_d;
      found_q   <= found_d;
      exh_q     <= exh_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    core_block_o = '0;
    for (int i = 0; i < 16; i++) begin
      core_block_o[511-32*i -: 32] = (i == int'(NONCE_WORD)) ? nonce_q : block[i];
    end
  end

  assign core_start_o = (state_q == StIssue);
  assign irq_o        = found_q | exh_q | timeout_q;

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Scoreboard bench for nonce_sweep_ctrl with a 65-cycle core stub (hash top = 0x100 - nonce).
module tb_nonce_sweep_ctrl;

  localparam logic [4:0] A_CTRL = 5'd16, A_NONCE = 5'd17, A_END = 5'd18;
  localparam logic [4:0] A_TGT = 5'd19, A_CNT = 5'd20;

  logic         clk = 1'b0;
  logic         reset, cs, wr, rd;
  logic [4:0]   addr;
  logic [31:0]  wdata, readdata;
  logic [511:0] core_block;
  logic         core_start, core_done, irq;
  logic [255:0] core_hash;

  int n_cmp = 0, n_err = 0, n_starts = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  logic [31:0] stub_nonce;
  int          stub_cnt;
  bit          stub_mute = 1'b0;

  always #5 clk = ~clk;

  nonce_sweep_ctrl dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .chipselect_i (cs),
    .write_i      (wr),
    .read_i       (rd),
    .address_i    (addr),
    .writedata_i  (wdata),
    .readdata_o   (readdata),
    .core_block_o (core_block),
    .core_start_o (core_start),
    .core_done_i  (core_done),
    .core_hash_i  (core_hash),
    .irq_o        (irq)
  );

  // Core stub: latch nonce word at start, answer 65 cycles later.
  always @(posedge clk) begin
    if (reset) begin
      core_done <= 1'b0;
      core_hash <= '0;
      stub_cnt  <= 0;
    end else begin
      core_done <= 1'b0;
      if (core_start && !stub_mute) begin
        stub_nonce <= core_block[511-32*3 -: 32];
        stub_cnt   <= 65;
      end else if (stub_cnt > 0) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1) begin
          core_done <= 1'b1;
          core_hash <= {32'h100 - stub_nonce, 224'h0};
        end
      end
    end
  end

  always @(posedge clk) if (core_start) n_starts++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: each accepted read presents readdata one edge later.
  initial begin
    logic [31:0] e;
    string nm;
    forever begin
      @(posedge clk);
      if (cs && rd) begin
        #1;
        if (exp_q.size() == 0) begin
          check("unexpected_read", readdata, 32'hx);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          check(nm, readdata, e);
        end
      end
    end
  end

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic rd_exp(input logic [4:0] a, input logic [31:0] e, input string nm);
    @(negedge clk);
    exp_q.push_back(e);
    name_q.push_back(nm);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic wait_irq(input int budget, output int used);
    used = 0;
    while (!irq && used < budget) begin
      @(negedge clk);
      used++;
    end
    check("irq_within_budget", {31'b0, irq}, 32'd1);
  endtask

  // Reference: walk the range with wide arithmetic, hash = 0x100 - nonce mod 2^32.
  task automatic model(input logic [31:0] s, input logic [31:0] e, input logic [31:0] t,
                       output bit f, output bit ex, output logic [31:0] g,
                       output logic [31:0] cnt, output logic [31:0] nfin);
    longint h;
    f = 0; ex = 0; g = 0; cnt = 0; nfin = s;
    if (longint'(e) < longint'(s)) begin
      ex = 1;
      return;
    end
    for (longint n = longint'(s); n <= longint'(e); n++) begin
      cnt++;
      nfin = n[31:0];
      h = (256 - n) & 64'hFFFF_FFFF;
      if (h < longint'(t)) begin
        f = 1;
        g = n[31:0];
        return;
      end
    end
    ex = 1;
  endtask

  task automatic run_sweep(input logic [31:0] s, input logic [31:0] e, input logic [31:0] t,
                           input string tag);
    bit f, ex;
    logic [31:0] g, cnt, nfin;
    int snap, used;
    model(s, e, t, f, ex, g, cnt, nfin);
    bus_wr(A_NONCE, s);
    bus_wr(A_END, e);
    bus_wr(A_TGT, t);
    snap = n_starts;
    bus_wr(A_CTRL, 32'h1);
    wait_irq(80 * (int'(cnt) + 1) + 20, used);
    if (cnt == 0) check({tag, "_empty_latency"}, {31'b0, used <= 2}, 32'd1);
    rd_exp(A_CTRL, {29'b0, ex, f, 1'b0}, {tag, "_status"});
    rd_exp(A_CNT, cnt, {tag, "_count"});
    rd_exp(A_NONCE, nfin, {tag, "_nonce"});
    if (f) rd_exp(A_END, g, {tag, "_golden"});
    check({tag, "_starts"}, n_starts - snap, cnt);
  endtask

  initial begin
    int snap, used;
    logic [31:0] s, e, t;
    int len;
    reset = 1'b1; cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_start", {31'b0, core_start}, 32'h0);
    check("rst_block_or", {31'b0, |core_block}, 32'h0);
    reset = 1'b0;
    rd_exp(A_CTRL, 32'h0, "rst_status");

    run_sweep(32'd0, 32'd10, 32'hFD, "hit");
    run_sweep(32'd10, 32'd9, 32'h0, "empty");
    run_sweep(32'd5, 32'd5, 32'h0, "single");
    run_sweep(32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, "top");

    for (int i = 0; i < 6; i++) begin
      s   = 32'hF8 + $urandom_range(0, 12);
      len = $urandom_range(0, 5);
      e   = (len == 0) ? s - 32'd1 : s + 32'(len) - 32'd1;
      t   = $urandom_range(0, 16);
      run_sweep(s, e, t, $sformatf("rnd%0d", i));
    end

    // Abort mid-WAIT, with an ignored TARGET write while busy.
    bus_wr(A_NONCE, 32'd0);
    bus_wr(A_END, 32'd10);
    bus_wr(A_TGT, 32'h0);
    snap = n_starts;
    bus_wr(A_CTRL, 32'h1);
    repeat (20) @(negedge clk);
    bus_wr(A_TGT, 32'hFFFF_FFFF);
    bus_wr(A_CTRL, 32'h2);
    rd_exp(A_CTRL, 32'h0, "abort_status");
    check("abort_irq", {31'b0, irq}, 32'h0);
    repeat (100) @(negedge clk);
    rd_exp(A_CNT, 32'h0, "abort_count");
    rd_exp(A_TGT, 32'h0, "abort_target");
    check("abort_starts", n_starts - snap, 32'd1);

`ifdef WATCHDOG_EN
    stub_mute = 1'b1;
    bus_wr(A_CTRL, 32'h1);
    wait_irq(300, used);
    rd_exp(A_CTRL, 32'h8, "wdog_status");
    rd_exp(A_CNT, 32'h0, "wdog_count");
    stub_mute = 1'b0;
    repeat (5) @(negedge clk);
`endif

    // Block substitution then reset mid-sweep.
    bus_wr(5'd0, 32'hDEAD_BEEF);
    bus_wr(5'd3, 32'h1234_5678);
    bus_wr(A_NONCE, 32'd7);
    bus_wr(A_END, 32'd20);
    bus_wr(A_CTRL, 32'h1);
    repeat (10) @(negedge clk);
    check("block_word0", core_block[511 -: 32], 32'hDEAD_BEEF);
    check("block_nonce_word", core_block[415 -: 32], 32'd7);
    rd_exp(5'd3, 32'h1234_5678, "word3_readback");
    rd_exp(5'd25, 32'h0, "unmapped_read");
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_start", {31'b0, core_start}, 32'h0);
    check("midrst_irq", {31'b0, irq}, 32'h0);
    check("midrst_readdata", readdata, 32'h0);
    check("midrst_block_or", {31'b0, |core_block}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd_exp(A_CTRL, 32'h0, "midrst_status");

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
